iq_multi: RTL and testbench

Parametrised N-wide successor to the single-issue instruction queue: a circular buffer between fetch2 (branch predictor) and decode. Accepts up to FETCH_W packets per cycle and presents up to DISP_W in-order packets per cycle. Supports partial dispatch when ROB/RS/free list have limited room, and a one-cycle flush on branch misprediction.

---
 rtl/iq_multi_pkg.sv | 27 ++
 rtl/iq_lane_compact.sv | 30 +++
 rtl/iq_multi.sv | 105 ++++++++++
 tb/tb_iq_multi.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/iq_multi_pkg.sv
// Shared packet type, defaults and pointer helper for the multi-wide instruction queue.
package iq_multi_pkg;

   localparam int IQ_DEPTH    = 16;
   localparam int FETCH_WIDTH = 2;
   localparam int DISP_WIDTH  = 2;

   localparam logic [31:0] NOOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic        valid_inst;
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] npc;
   } INST_Q;

   localparam INST_Q NOOP_PKT = '{valid_inst: 1'b0, ir: NOOP_INST, pc: 32'd0, npc: 32'd0};

   // Wrap by compare so non-power-of-two depths work; requires p < depth and n <= depth.
   function automatic int unsigned ptr_add(input int unsigned p, input int unsigned n,
                                           input int unsigned depth);
      int unsigned s;
      s = p + n;
      return (s >= depth) ? (s - depth) : s;
   endfunction

endpackage

// File: rtl/iq_lane_compact.sv
// Packs the valid fetch lanes toward slot 0 in lane order and reports how many there are.
module iq_lane_compact
   import iq_multi_pkg::*;
#(
   parameter int FETCH_W = FETCH_WIDTH,
   localparam int FCW    = $clog2(FETCH_W + 1)
) (
   input  logic [FETCH_W-1:0]  valid_i,
   input  INST_Q [FETCH_W-1:0] inst_i,
   output INST_Q [FETCH_W-1:0] packed_o,
   output logic [FCW-1:0]      cnt_o
);

   // Running prefix count of valid lanes selects each lane's destination slot.
   always_comb begin
      logic [FCW-1:0] run_s;
      run_s = '0;
      for (int j = 0; j < FETCH_W; j++) begin
         packed_o[j] = NOOP_PKT;
      end
      for (int l = 0; l < FETCH_W; l++) begin
         for (int j = 0; j < FETCH_W; j++) begin
            packed_o[j] = (valid_i[l] && (FCW'(j) == run_s)) ? inst_i[l] : packed_o[j];
         end
         run_s = run_s + FCW'(valid_i[l]);
      end
      cnt_o = run_s;
   end

endmodule

// File: rtl/iq_multi.sv
// N-wide circular instruction queue between fetch and decode with partial dispatch and flush.
module iq_multi
   import iq_multi_pkg::*;
#(
   parameter int DEPTH   = IQ_DEPTH,
   parameter int FETCH_W = FETCH_WIDTH,
   parameter int DISP_W  = DISP_WIDTH,
   localparam int AW     = $clog2(DISP_W + 1),
   localparam int CW     = $clog2(DEPTH + 1),
   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int FCW    = $clog2(FETCH_W + 1)
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic [FETCH_W-1:0]  fetch_valid_i,
   input  INST_Q [FETCH_W-1:0] fetch_inst_i,
   input  logic [AW-1:0]       disp_avail_i,
   input  logic                branch_incorrect_i,
   output logic [DISP_W-1:0]   disp_valid_o,
   output INST_Q [DISP_W-1:0]  disp_inst_o,
   output logic                iq_stall_o,
   output logic [CW-1:0]       iq_count_o
);

   INST_Q [DEPTH-1:0]   entries_q;
   logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]       count_q, count_d;
   logic                stall_q, stall_d;

   INST_Q [FETCH_W-1:0] packed_s;
   logic [FCW-1:0]      pop_s;
   logic [CW-1:0]       avail_s, deq_s, enq_s;
   logic [PW-1:0]       waddr_s [FETCH_W];
   logic                wr_en_s;

   iq_lane_compact #(.FETCH_W(FETCH_W)) u_compact (
      .valid_i  (fetch_valid_i),
      .inst_i   (fetch_inst_i),
      .packed_o (packed_s),
      .cnt_o    (pop_s)
   );

   // Dequeue/enqueue amounts and next pointer state; flush wipes the queue.
   always_comb begin
      avail_s = (disp_avail_i > AW'(DISP_W)) ? CW'(DISP_W) : CW'(disp_avail_i);
      deq_s   = (avail_s < count_q) ? avail_s : count_q;
      enq_s   = stall_q ? '0 : CW'(pop_s);
      wr_en_s = !branch_incorrect_i && !stall_q;
      for (int k = 0; k < FETCH_W; k++) begin
         waddr_s[k] = PW'(ptr_add(32'(tail_q), k, DEPTH));
      end
      if (branch_incorrect_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = PW'(ptr_add(32'(head_q), 32'(deq_s), DEPTH));
         tail_d  = PW'(ptr_add(32'(tail_q), 32'(enq_s), DEPTH));
         count_d = count_q + enq_s - deq_s;
      end
      stall_d = (count_d > CW'(DEPTH - FETCH_W));
   end

   // Pointer, count and stall registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         stall_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         stall_q <= stall_d;
      end
   end

   // Entry storage; contents are don't-care once outside the head..tail window.
   always_ff @(posedge clock_i) begin
      if (!reset_i && wr_en_s) begin
         for (int k = 0; k < FETCH_W; k++) begin
            if (FCW'(k) < pop_s) begin
               entries_q[waddr_s[k]] <= packed_s[k];
            end
         end
      end
   end

   // Head-relative read view; lanes beyond count (or any lane during flush) show NOOP.
   always_comb begin
      for (int i = 0; i < DISP_W; i++) begin
         logic [PW-1:0] ridx_s;
         logic          ok_s;
         ridx_s          = PW'(ptr_add(32'(head_q), i, DEPTH));
         ok_s            = (CW'(i) < count_q) && !branch_incorrect_i;
         disp_valid_o[i] = ok_s;
         disp_inst_o[i]  = ok_s ? entries_q[ridx_s] : NOOP_PKT;
      end
   end

   assign iq_stall_o = stall_q;
   assign iq_count_o = count_q;

endmodule

// File: tb/tb_iq_multi.sv
// Scoreboard bench for iq_multi: the driver pushes expected views from a packet-queue model, a monitor compares.
module tb_iq_multi;
   import iq_multi_pkg::*;

   localparam int DEPTH   = 5;
   localparam int FETCH_W = 2;
   localparam int DISP_W  = 2;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic [FETCH_W-1:0]  fetch_valid = '0;
   INST_Q [FETCH_W-1:0] fetch_inst;
   logic [1:0]          disp_avail = 2'd0;
   logic                branch_incorrect = 1'b0;
   logic [DISP_W-1:0]   disp_valid;
   INST_Q [DISP_W-1:0]  disp_inst;
   logic                iq_stall;
   logic [2:0]          iq_count;

   typedef struct {
      logic [DISP_W-1:0] v;
      INST_Q             inst [DISP_W];
      logic [2:0]        cnt;
      logic              stall;
   } exp_t;

   exp_t  exp_q [$];
   INST_Q mq [$];
   int    n_checks = 0;
   int    n_fail   = 0;

   iq_multi #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .DISP_W(DISP_W)) dut (
      .clock_i            (clock),
      .reset_i            (reset),
      .fetch_valid_i      (fetch_valid),
      .fetch_inst_i       (fetch_inst),
      .disp_avail_i       (disp_avail),
      .branch_incorrect_i (branch_incorrect),
      .disp_valid_o       (disp_valid),
      .disp_inst_o        (disp_inst),
      .iq_stall_o         (iq_stall),
      .iq_count_o         (iq_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // One cycle: drive inputs, record the expected view of current state, then advance the model.
   task automatic step(input logic rst, input logic [1:0] fv, input logic [1:0] av,
                       input logic fl, input logic [31:0] n0, input logic [31:0] n1);
      exp_t e;
      int   a, d;
      logic st;
      @(negedge clock);
      reset            = rst;
      fetch_valid      = fv;
      disp_avail       = av;
      branch_incorrect = fl;
      fetch_inst[0]    = '{valid_inst: 1'b1, ir: $urandom, pc: $urandom, npc: n0};
      fetch_inst[1]    = '{valid_inst: 1'b1, ir: $urandom, pc: $urandom, npc: n1};
      st = (DEPTH - mq.size()) < FETCH_W;
      for (int i = 0; i < DISP_W; i++) begin
         e.v[i]    = (i < mq.size()) && !fl;
         e.inst[i] = e.v[i] ? mq[i] : NOOP_PKT;
      end
      e.cnt   = 3'(mq.size());
      e.stall = st;
      exp_q.push_back(e);
      if (rst || fl) begin
         mq.delete();
      end else begin
         a = (av > DISP_W) ? DISP_W : int'(av);
         d = (a < mq.size()) ? a : mq.size();
         repeat (d) void'(mq.pop_front());
         if (!st) begin
            for (int l = 0; l < FETCH_W; l++) begin
               if (fv[l]) mq.push_back(fetch_inst[l]);
            end
         end
      end
   endtask

   // Monitor: compares the DUT view against the oldest pending expectation.
   always @(negedge clock) begin
      exp_t e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("disp_valid", 128'(disp_valid), 128'(e.v));
         chk("disp_inst0", 128'(disp_inst[0]), 128'(e.inst[0]));
         chk("disp_inst1", 128'(disp_inst[1]), 128'(e.inst[1]));
         chk("iq_count", 128'(iq_count), 128'(e.cnt));
         chk("iq_stall", 128'(iq_stall), 128'(e.stall));
      end
   end

   initial begin
      fetch_inst[0] = NOOP_PKT;
      fetch_inst[1] = NOOP_PKT;
      repeat (2) @(posedge clock);
      repeat (3) step(1'b0, 2'b00, 2'd0, 1'b0, 32'd0, 32'd0);
      // fill until stall, then a dropped pair
      step(1'b0, 2'b11, 2'd0, 1'b0, 32'd4, 32'd8);
      step(1'b0, 2'b11, 2'd0, 1'b0, 32'd12, 32'd16);
      step(1'b0, 2'b11, 2'd0, 1'b0, 32'd20, 32'd24);
      step(1'b0, 2'b00, 2'd0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 2'b00, 2'd1, 1'b0, 32'd0, 32'd0);
      step(1'b0, 2'b00, 2'd0, 1'b0, 32'd0, 32'd0);
      // flush with 3 held, fetch and dispatch requested
      step(1'b0, 2'b11, 2'd2, 1'b1, 32'd28, 32'd32);
      step(1'b0, 2'b00, 2'd0, 1'b0, 32'd0, 32'd0);
      // lane 1 only into an empty queue
      step(1'b0, 2'b10, 2'd0, 1'b0, 32'd0, 32'd20);
      step(1'b0, 2'b00, 2'd0, 1'b0, 32'd0, 32'd0);
      // reach full, then stall while dequeuing; avail=3 saturates
      step(1'b0, 2'b11, 2'd0, 1'b0, 32'd36, 32'd40);
      step(1'b0, 2'b11, 2'd3, 1'b0, 32'd44, 32'd48);
      step(1'b0, 2'b11, 2'd0, 1'b0, 32'd52, 32'd56);
      step(1'b0, 2'b11, 2'd2, 1'b0, 32'd60, 32'd64);
      step(1'b0, 2'b00, 2'd2, 1'b0, 32'd0, 32'd0);
      step(1'b0, 2'b00, 2'd3, 1'b0, 32'd0, 32'd0);
      step(1'b0, 2'b00, 2'd2, 1'b0, 32'd0, 32'd0);
      // reset in the middle of traffic
      step(1'b0, 2'b11, 2'd0, 1'b0, 32'd68, 32'd72);
      step(1'b1, 2'b11, 2'd2, 1'b0, 32'd76, 32'd80);
      step(1'b0, 2'b00, 2'd0, 1'b0, 32'd0, 32'd0);
      for (int c = 0; c < 800; c++) begin
         step(($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0),
              $urandom, $urandom);
      end
      step(1'b0, 2'b00, 2'd0, 1'b0, 32'd0, 32'd0);
      @(negedge clock);
      #4;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
